// File: rtl/ave8_bcd_display_if.sv
// Averager-to-display bus: the sampled 8-bit average going in, seven-segment
// digits and status coming out.
interface ave8_bcd_display_if;
    logic [0:7] avg_in;
    logic       avg_valid;
    logic [0:6] seg_hun;
    logic [0:6] seg_tens;
    logic [0:6] seg_units;
    logic       busy;
    logic       upd;

    modport master (
        output avg_in, avg_valid,
        input  seg_hun, seg_tens, seg_units, busy, upd
    );

    modport slave (
        input  avg_in, avg_valid,
        output seg_hun, seg_tens, seg_units, busy, upd
    );
endinterface

// File: rtl/ave8_bcd_display.sv
// Periodically samples the 8-bit average, converts it to BCD with a
// one-shift-per-clock double-dabble engine and drives three 7-seg digits.
module ave8_bcd_display #(
    parameter int HOLD_CYCLES = 1000000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    ave8_bcd_display_if.slave bus
);
    localparam int         CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_ZERO  = 7'b1000000;
    localparam logic [0:6] SEG_LZ    = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {S_WAIT = 2'd0, S_CONV = 2'd1, S_LOAD = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    iter;
    logic [7:0]    shf;
    logic [3:0]    hun, tens, units;
    logic          capture, load, busy;
    logic [0:6]    seg_hun_q, seg_tens_q, seg_units_q;
    logic          upd_q;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:  if (cnt == '0 && bus.avg_valid) state_nxt = S_CONV;
            S_CONV:  if (iter == 3'd7) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        load    = 1'b0;
        busy    = 1'b0;
        case (state)
            S_WAIT:  capture = (cnt == '0) && bus.avg_valid;
            S_CONV:  busy = 1'b1;
            S_LOAD:  begin busy = 1'b1; load = 1'b1; end
            default: ;
        endcase
    end

    // Digits are adjusted before the shift; hun never exceeds 2 so its top bit
    // falling off the end of the shift loses nothing.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            iter  <= '0;
            shf   <= '0;
            hun   <= '0;
            tens  <= '0;
            units <= '0;
        end else begin
            if (state == S_WAIT && cnt != '0) cnt <= cnt - CW'(1);
            if (load) cnt <= CW'(HOLD_CYCLES - 1);
            if (capture) begin
                shf   <= bus.avg_in;
                hun   <= '0;
                tens  <= '0;
                units <= '0;
                iter  <= '0;
            end else if (state == S_CONV) begin
                {hun, tens, units, shf} <= {add3(hun), add3(tens), add3(units), shf} << 1;
                iter <= iter + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            seg_hun_q   <= SEG_LZ;
            seg_tens_q  <= SEG_LZ;
            seg_units_q <= SEG_ZERO;
            upd_q       <= 1'b0;
        end else begin
            upd_q <= load;
            if (load) begin
                seg_hun_q   <= (BLANK_LZ && hun == 4'd0) ? SEG_BLANK : seg7(hun);
                seg_tens_q  <= (BLANK_LZ && hun == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
                seg_units_q <= seg7(units);
            end
        end
    end

    assign bus.seg_hun   = seg_hun_q;
    assign bus.seg_tens  = seg_tens_q;
    assign bus.seg_units = seg_units_q;
    assign bus.busy      = busy;
    assign bus.upd       = upd_q;
endmodule

// File: tb/tb_ave8_bcd_display.sv
// Bench: two displays (leading-zero blanking on/off) share one stimulus stream
// and are checked every cycle against a decimal-arithmetic timing model.
module tb_ave8_bcd_display;
    localparam int         HOLD  = 4;
    localparam logic [0:6] BLANK = 7'b1111111;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic cmp_en = 1'b0;

    ave8_bcd_display_if b0 ();
    ave8_bcd_display_if b1 ();
    assign b1.avg_in    = b0.avg_in;
    assign b1.avg_valid = b0.avg_valid;

    ave8_bcd_display #(.HOLD_CYCLES(HOLD), .BLANK_LZ(1'b1)) dut0 (.CLOCK(CLOCK), .RESET(RESET), .bus(b0.slave));
    ave8_bcd_display #(.HOLD_CYCLES(HOLD), .BLANK_LZ(1'b0)) dut1 (.CLOCK(CLOCK), .RESET(RESET), .bus(b1.slave));

    always #5 CLOCK = ~CLOCK;

    function automatic logic [0:6] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a capture is followed 9 edges later by the new digits, after
    // which the next capture is allowed HOLD edges on.
    int         m_wait, m_conv, m_val;
    logic [0:6] e_hun0, e_tens0, e_hun1, e_tens1, e_units;
    logic       e_upd;

    always @(posedge CLOCK or negedge RESET) begin
        int h, t, u;
        if (!RESET) begin
            m_wait = 0; m_conv = 0; e_upd = 1'b0;
            e_units = enc(0); e_hun0 = BLANK; e_tens0 = BLANK;
            e_hun1 = enc(0); e_tens1 = enc(0);
        end else begin
            e_upd = 1'b0;
            if (m_conv > 0) begin
                m_conv--;
                if (m_conv == 0) begin
                    h = m_val / 100; t = (m_val / 10) % 10; u = m_val % 10;
                    e_hun1  = enc(h);
                    e_tens1 = enc(t);
                    e_units = enc(u);
                    e_hun0  = (h == 0) ? BLANK : enc(h);
                    e_tens0 = (h == 0 && t == 0) ? BLANK : enc(t);
                    e_upd   = 1'b1;
                    m_wait  = HOLD - 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (b0.avg_valid === 1'b1) begin
                m_val  = int'(b0.avg_in);
                m_conv = 9;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (cmp_en) begin
            chk("hun0",   b0.seg_hun,   e_hun0);
            chk("tens0",  b0.seg_tens,  e_tens0);
            chk("units0", b0.seg_units, e_units);
            chk("busy0",  b0.busy,      int'(m_conv > 0));
            chk("upd0",   b0.upd,       e_upd);
            chk("hun1",   b1.seg_hun,   e_hun1);
            chk("tens1",  b1.seg_tens,  e_tens1);
            chk("units1", b1.seg_units, e_units);
            chk("busy1",  b1.busy,      int'(m_conv > 0));
            chk("upd1",   b1.upd,       e_upd);
        end
    end

    task automatic wait_upd(output int n);
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (b0.upd !== 1'b1 && n < 100);
        chk("upd_seen", b0.upd, 1);
    endtask

    task automatic wait_busy();
        int n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (b0.busy !== 1'b1 && n < 100);
        chk("busy_seen", b0.busy, 1);
    endtask

    task automatic lit(input string tag, input logic [0:6] h, input logic [0:6] t, input logic [0:6] u);
        chk({tag, "_hun"},   b0.seg_hun,   h);
        chk({tag, "_tens"},  b0.seg_tens,  t);
        chk({tag, "_units"}, b0.seg_units, u);
    endtask

    initial begin
        int n;
        b0.avg_in = 8'd0;
        b0.avg_valid = 1'b0;
        #7 cmp_en = 1'b1;
        @(negedge CLOCK); @(negedge CLOCK);
        lit("rst", 7'b1111111, 7'b1111111, 7'b1000000);
        chk("rst_hun_lz0", b1.seg_hun, 7'b1000000);
        chk("rst_busy", b0.busy, 0);

        // first capture on the first edge after release
        RESET = 1'b1; b0.avg_valid = 1'b1; b0.avg_in = 8'd0;
        wait_upd(n);
        chk("lat_first", n, 10);
        lit("v0", 7'b1111111, 7'b1111111, 7'b1000000);

        b0.avg_in = 8'd255;
        wait_upd(n);
        chk("period", n, 13);
        lit("v255", 7'b0100100, 7'b0010010, 7'b0010010);

        b0.avg_in = 8'd100;
        wait_upd(n);
        lit("v100", 7'b1111001, 7'b1000000, 7'b1000000);
        b0.avg_in = 8'd9;
        wait_upd(n);
        lit("v9", 7'b1111111, 7'b1111111, 7'b0010000);
        chk("v9_lz0_hun", b1.seg_hun, 7'b1000000);
        chk("v9_lz0_tens", b1.seg_tens, 7'b1000000);

        // input changes mid-conversion must not disturb the captured value
        b0.avg_in = 8'd37;
        wait_busy();
        b0.avg_in = 8'd200;
        wait_upd(n);
        lit("v37", 7'b1111111, 7'b0110000, 7'b1111000);
        wait_upd(n);
        lit("v200", 7'b0100100, 7'b1000000, 7'b1000000);

        b0.avg_valid = 1'b0;
        repeat (20) begin
            @(negedge CLOCK);
            chk("novalid_busy", b0.busy, 0);
            chk("novalid_upd", b0.upd, 0);
        end
        b0.avg_in = 8'd42; b0.avg_valid = 1'b1;
        wait_upd(n);
        chk("lat_valid", n, 10);
        lit("v42", 7'b1111111, 7'b0011001, 7'b0100100);

        // reset in the middle of a conversion
        b0.avg_in = 8'd255;
        wait_busy();
        repeat (4) @(negedge CLOCK);
        #3 RESET = 1'b0;
        #1;
        lit("midrst", 7'b1111111, 7'b1111111, 7'b1000000);
        chk("midrst_busy", b0.busy, 0);
        repeat (2) begin
            @(negedge CLOCK);
            chk("midrst_upd", b0.upd, 0);
        end
        RESET = 1'b1;
        wait_upd(n);
        chk("lat_after_rst", n, 10);
        lit("post_rst", 7'b0100100, 7'b0010010, 7'b0010010);

        repeat (800) begin
            @(negedge CLOCK);
            b0.avg_in = 8'($urandom_range(0, 255));
            b0.avg_valid = ($urandom_range(0, 3) != 0);
        end

        @(negedge CLOCK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ave8_bcd_display.md
Name: ave8_bcd_display

Overview:
- Sits directly downstream of the 8-tap averager and consumes its 8-bit average output.
- Periodically samples the average and converts it to three BCD digits with a sequential double-dabble engine (one shift per clock).
- Drives the hundreds/tens/units seven-segment displays from registered outputs.
- Replaces the direct 3-bit-slice decoding with a correct decimal display that holds steady between updates.

Parameters:
- HOLD_CYCLES, default 1000000: cycles spent in WAIT between display updates. Legal range is 1 or more. Update period = HOLD_CYCLES + 9 cycles.
- BLANK_LZ, default 1: when 1, leading-zero digits are blanked. When 0, all three digits are always shown.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset. Asserted when 0.
- avg_in  in  [0:7]  unsigned average from the averager; bit 0 is the MSB.
- avg_valid  in  1  avg_in is usable this cycle. Tie to 1 when driven by the free-running averager.
- seg_hun  out  [0:6]  hundreds digit segments, active-low.
- seg_tens  out  [0:6]  tens digit segments, active-low.
- seg_units  out  [0:6]  units digit segments, active-low.
- busy  out  1  high while in CONV or LOAD.
- upd  out  1  one-cycle pulse on the cycle new segment values first appear.

Behaviour:
- Reset (async, while RESET=0):
  - state=WAIT, hold counter=0, shift/BCD registers=0, busy=0, upd=0.
  - seg_units=1000000 ("0").
  - seg_tens=seg_hun=1111111 (blank) if BLANK_LZ=1; 1000000 if BLANK_LZ=0.
  - Reset mid-conversion aborts the conversion with no partial display update.
- Segment encoding, string index 0..6 = port bit 0..6:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111
- FSM state WAIT:
  - If counter != 0, decrement it.
  - If counter==0 and avg_valid=1: capture avg_in into an 8-bit shift register, clear BCD (hun 4b, tens 4b, units 4b), clear iteration count, go to CONV.
  - If counter==0 and avg_valid=0: stay in WAIT with counter at 0. Capture happens on the first cycle avg_valid=1.
- FSM state CONV, 8 cycles:
  - Each cycle, every BCD digit >= 5 gets +3, then {hun,tens,units,shift} shifts left 1, with the shift register MSB entering units LSB.
  - Iteration 7 completes, then go to LOAD.
  - avg_in and avg_valid are ignored in CONV.
- FSM state LOAD, 1 cycle:
  - Decode the digits into the seg_* registers and pulse upd=1.
  - Reload counter with HOLD_CYCLES-1 and go to WAIT.
- Latency: capture edge N, CONV edges N+1..N+8, seg_* and upd change on edge N+9.
  - The first capture after reset release occurs on the first edge with avg_valid=1.
- Blanking, BLANK_LZ=1:
  - hun blanked iff hun==0.
  - tens blanked iff hun==0 and tens==0.
  - units never blanked.
- Arithmetic limits:
  - The hundreds digit never exceeds 2 (input max 255).
  - The add-3 step is done on 4-bit digits before the shift; no carry between digits beyond the shift.
- Outputs are registered only. No combinational path from avg_in to seg_*.
- seg_* hold their value in all states other than LOAD.
- busy=1 in CONV and LOAD, 0 in WAIT.

Test Plan:
- HOLD_CYCLES=4, BLANK_LZ=1, avg_in=0, valid=1 after reset release:
  - upd pulses 9 cycles after capture.
  - seg_units=1000000, seg_tens=seg_hun=1111111.
- avg_in=255:
  - seg_hun=0100100 (2), seg_tens=0010010 (5), seg_units=0010010 (5).
  - Next upd exactly 13 cycles after the previous one.
- avg_in=100 then 9:
  - First update: hun=1111001, tens=1000000 (not blanked), units=1000000.
  - Second update: hun and tens blank, units=0010000.
  - With BLANK_LZ=0, 9 gives hun=tens=1000000.
- avg_in changed from 37 to 200 during CONV:
  - Display shows 3,7 (tens=0110000, units=1111000, hun blank).
  - 200 appears only on the following update.
- avg_valid held 0 for 20 cycles at counter 0:
  - No capture, busy=0, no upd.
  - Raising avg_valid with avg_in=42 gives capture that edge and tens=0011001, units=0100100 nine cycles later.
- RESET pulsed low at CONV iteration 4 of 255:
  - Outputs go immediately to reset values, upd stays 0.
  - After release, a fresh conversion completes normally.
